// File: rtl/cordic_sequencer.sv
// Iterative rotation-mode controller for a single-iteration CORDIC stage:
// loads x=K, y=0, z=angle, runs N_ITERATIONS passes and returns cos/sin.
//
// state | meaning
// IDLE  | waiting for an angle, ready_o high
// RUN   | one stage pass per cycle, state registers fed back from next_*_i
// DONE  | result held on cos_o/sin_o with valid_o high until ready_i
module cordic_sequencer #(
    parameter int WORD_LENGTH  = 21,
    parameter int FRAC_BITS    = 19,
    parameter int N_ITERATIONS = 17
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WORD_LENGTH-1:0] angle_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic signed [WORD_LENGTH-1:0] cos_o,
    output logic signed [WORD_LENGTH-1:0] sin_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic signed [WORD_LENGTH-1:0] x_o,
    output logic signed [WORD_LENGTH-1:0] y_o,
    output logic signed [WORD_LENGTH-1:0] z_o,
    output logic signed [WORD_LENGTH-1:0] alpha_o,
    output logic        [4:0]             iteration_o,
    input  logic signed [WORD_LENGTH-1:0] next_x_i,
    input  logic signed [WORD_LENGTH-1:0] next_y_i,
    input  logic signed [WORD_LENGTH-1:0] next_z_i
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Constants are tabulated in Q.19 and rescaled (with rounding) to FRAC_BITS.
    function automatic logic signed [WORD_LENGTH-1:0] scale_q19(input int value);
        longint tmp;
        int     sh_up;
        int     sh_dn;
        sh_up = (FRAC_BITS >= 19) ? FRAC_BITS - 19 : 0;
        sh_dn = (FRAC_BITS < 19) ? 19 - FRAC_BITS : 0;
        tmp   = longint'(value) <<< sh_up;
        if (sh_dn > 0) begin
            tmp = (tmp + (64'sd1 <<< (sh_dn - 1))) >>> sh_dn;
        end
        return tmp[WORD_LENGTH-1:0];
    endfunction

    function automatic int atan_q19(input logic [4:0] idx);
        case (idx)
            5'd0:    return 411775;
            5'd1:    return 243085;
            5'd2:    return 128439;
            5'd3:    return 65198;
            5'd4:    return 32725;
            5'd5:    return 16379;
            5'd6:    return 8191;
            5'd7:    return 4096;
            5'd8:    return 2048;
            5'd9:    return 1024;
            5'd10:   return 512;
            5'd11:   return 256;
            5'd12:   return 128;
            5'd13:   return 64;
            5'd14:   return 32;
            5'd15:   return 16;
            5'd16:   return 8;
            5'd17:   return 4;
            5'd18:   return 2;
            5'd19:   return 1;
            default: return 0;
        endcase
    endfunction

    localparam logic signed [WORD_LENGTH-1:0] K_INIT    = scale_q19(318375);
    localparam logic        [4:0]             LAST_ITER = 5'(N_ITERATIONS - 1);

    state_t                          state;
    logic signed [WORD_LENGTH-1:0]   x_q;
    logic signed [WORD_LENGTH-1:0]   y_q;
    logic signed [WORD_LENGTH-1:0]   z_q;
    logic        [4:0]               iter_q;
    logic                            valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        x_q    <= K_INIT;
                        y_q    <= '0;
                        z_q    <= angle_i;
                        iter_q <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x_q <= next_x_i;
                    y_q <= next_y_i;
                    z_q <= next_z_i;
                    if (iter_q == LAST_ITER) begin
                        iter_q  <= '0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        iter_q <= iter_q + 5'd1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ready_o is held low while reset is asserted even though state is IDLE.
    assign ready_o     = rst && (state == IDLE);
    assign valid_o     = valid_q;
    assign cos_o       = x_q;
    assign sin_o       = y_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign z_o         = z_q;
    assign iteration_o = iter_q;

    always_comb begin
        alpha_o = scale_q19(atan_q19(iter_q));
    end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer with a behavioural rotation-mode CORDIC stage
// closing the loop; results are compared to double-precision cos/sin.
module tb_cordic_sequencer;
    localparam int WL  = 21;
    localparam int FB  = 19;
    localparam int N   = 17;
    localparam int TOL = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [WL-1:0] angle_i;
    logic                 valid_i;
    logic                 ready_o;
    logic signed [WL-1:0] cos_o, sin_o;
    logic                 valid_o;
    logic                 ready_i;
    logic signed [WL-1:0] x_o, y_o, z_o, alpha_o;
    logic [4:0]           iteration_o;
    logic signed [WL-1:0] next_x_i, next_y_i, next_z_i;

    int tests = 0;
    int fails = 0;

    cordic_sequencer #(.WORD_LENGTH(WL), .FRAC_BITS(FB), .N_ITERATIONS(N)) dut (
        .clk(clk), .rst(rst), .angle_i(angle_i), .valid_i(valid_i), .ready_o(ready_o),
        .cos_o(cos_o), .sin_o(sin_o), .valid_o(valid_o), .ready_i(ready_i),
        .x_o(x_o), .y_o(y_o), .z_o(z_o), .alpha_o(alpha_o), .iteration_o(iteration_o),
        .next_x_i(next_x_i), .next_y_i(next_y_i), .next_z_i(next_z_i)
    );

    always #5 clk = ~clk;

    // Single-iteration rotation stage: rotate toward z = 0.
    always_comb begin
        if (!z_o[WL-1]) begin
            next_x_i = x_o - (y_o >>> iteration_o);
            next_y_i = y_o + (x_o >>> iteration_o);
            next_z_i = z_o - alpha_o;
        end else begin
            next_x_i = x_o + (y_o >>> iteration_o);
            next_y_i = y_o - (x_o >>> iteration_o);
            next_z_i = z_o + alpha_o;
        end
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp);
        tests++;
        assert ((obs - exp <= TOL) && (exp - obs <= TOL)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
        end
    endtask

    // Present an angle at a falling edge and wait until valid_o rises.
    task automatic send(input logic signed [WL-1:0] a, input string tag);
        int cycles;
        check_eq({tag, "_ready_before"}, longint'(ready_o), 1);
        angle_i = a;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        angle_i = WL'($urandom);
        cycles  = 0;
        while (!valid_o && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_latency"}, longint'(cycles), N);
    endtask

    task automatic check_result(input logic signed [WL-1:0] a, input string tag);
        real ar;
        ar = real'(a) / (2.0 ** FB);
        check_near({tag, "_cos"}, longint'(cos_o), longint'($cos(ar) * (2.0 ** FB)));
        check_near({tag, "_sin"}, longint'(sin_o), longint'($sin(ar) * (2.0 ** FB)));
    endtask

    task automatic complete(input string tag);
        ready_i = 1'b1;
        @(negedge clk);
        check_eq({tag, "_valid_clear"}, longint'(valid_o), 0);
        check_eq({tag, "_ready_back"}, longint'(ready_o), 1);
    endtask

    initial begin
        logic signed [WL-1:0] a;
        logic signed [WL-1:0] held_cos, held_sin;
        logic signed [WL-1:0] directed [4];
        int cycles;

        directed[0] = 21'sd411775;
        directed[1] = -21'sd411775;
        directed[2] = 21'sd823550;
        directed[3] = -21'sd823550;

        rst = 1'b0; angle_i = '0; valid_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        check_eq("reset_ready_low", longint'(ready_o), 0);
        @(negedge clk);
        check_eq("reset_valid", longint'(valid_o), 0);
        check_eq("reset_x", longint'(x_o), 0);
        check_eq("reset_iter", longint'(iteration_o), 0);
        rst = 1'b1;
        #1;
        check_eq("release_ready", longint'(ready_o), 1);
        @(negedge clk);

        // angle 0 with load/ROM checks on the first two iterations
        angle_i = '0;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check_eq("load_x", longint'(x_o), 318375);
        check_eq("load_y", longint'(y_o), 0);
        check_eq("load_z", longint'(z_o), 0);
        check_eq("run_ready_low", longint'(ready_o), 0);
        check_eq("alpha0", longint'(alpha_o), 411775);
        @(negedge clk);
        check_eq("iter1", longint'(iteration_o), 1);
        check_eq("alpha1", longint'(alpha_o), 243085);
        cycles = 1;
        while (!valid_o && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        check_eq("zero_latency", longint'(cycles), N);
        check_result('0, "zero");
        complete("zero");

        foreach (directed[i]) begin
            send(directed[i], "directed");
            check_result(directed[i], "directed");
            complete("directed");
        end

        // backpressure: result held while new angles are offered
        ready_i = 1'b0;
        a = 21'sd200000;
        send(a, "bp");
        check_result(a, "bp");
        held_cos = cos_o;
        held_sin = sin_o;
        for (int k = 0; k < 5; k++) begin
            angle_i = WL'($urandom_range(0, 1647100)) - 21'sd823550;
            valid_i = 1'b1;
            @(negedge clk);
            check_eq("bp_valid_hold", longint'(valid_o), 1);
            check_eq("bp_cos_hold", longint'(cos_o), longint'(held_cos));
            check_eq("bp_sin_hold", longint'(sin_o), longint'(held_sin));
            check_eq("bp_ready_low", longint'(ready_o), 0);
        end
        valid_i = 1'b0;
        complete("bp");
        @(negedge clk);
        check_eq("bp_no_accept", longint'(ready_o), 1);

        // reset in the middle of RUN
        angle_i = 21'sd300000;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("mid_iter8", longint'(iteration_o), 8);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_valid", longint'(valid_o), 0);
        check_eq("mid_x", longint'(x_o), 0);
        check_eq("mid_y", longint'(y_o), 0);
        check_eq("mid_z", longint'(z_o), 0);
        check_eq("mid_iter", longint'(iteration_o), 0);
        check_eq("mid_ready_gated", longint'(ready_o), 0);
        rst = 1'b1;
        #1;
        check_eq("mid_ready_release", longint'(ready_o), 1);
        repeat (20) begin
            @(negedge clk);
            check_eq("aborted_no_valid", longint'(valid_o), 0);
        end
        send('0, "after_reset");
        check_result('0, "after_reset");
        complete("after_reset");

        // randomized back-to-back sweep
        ready_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            a = WL'($urandom_range(0, 1647100)) - 21'sd823550;
            send(a, "sweep");
            check_result(a, "sweep");
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
